instr_loader: RTL and testbench

Sequential instruction encoder and loader feeding the single-cycle MIPS datapath. It accepts mnemonic-level instruction commands over a valid/ready stream and encodes each into a 32-bit MIPS word. It uses the opcode/funct values the control decoder recognises: R-type funct, lw, sw, beq, bmn (opcode 21), jal, and jmadd (funct 31). It writes the words sequentially into instruction memory and holds the CPU stalled until loading completes.

---
 rtl/mips_pkg.sv | 56 +++++
 rtl/instr_encoder.sv | 42 ++++
 rtl/instr_loader.sv | 158 +++++++++++++++
 tb/tb_instr_loader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
//==============================================================================
// Module : mips_pkg
// Shared command, opcode and funct encodings for the loader and control decoder.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package mips_pkg;

    typedef enum logic [3:0] {
        CMD_ADD   = 4'd0,
        CMD_SUB   = 4'd1,
        CMD_AND   = 4'd2,
        CMD_OR    = 4'd3,
        CMD_SLT   = 4'd4,
        CMD_JMADD = 4'd5,
        CMD_LW    = 4'd6,
        CMD_SW    = 4'd7,
        CMD_BEQ   = 4'd8,
        CMD_BMN   = 4'd9,
        CMD_JAL   = 4'd10
    } cmd_op_e;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BMN   = 6'd21;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] F_ADD    = 6'h20;
    localparam logic [5:0] F_SUB    = 6'h22;
    localparam logic [5:0] F_AND    = 6'h24;
    localparam logic [5:0] F_OR     = 6'h25;
    localparam logic [5:0] F_SLT    = 6'h2A;
    localparam logic [5:0] F_JMADD  = 6'h1F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } ld_state_e;

    function automatic logic [31:0] rtype_word(input logic [4:0] rs, input logic [4:0] rt,
                                               input logic [4:0] rd, input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] itype_word(input logic [5:0] op, input logic [4:0] rs,
                                               input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_encoder.sv
//==============================================================================
// Module : instr_encoder
// Combinational mnemonic-to-MIPS-word encoder with a legality flag.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module instr_encoder
    import mips_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [15:0] i_imm,
    input  logic [25:0] i_target,
    output logic [31:0] o_word,
    output logic        o_legal
);

    always_comb begin
        o_word  = '0;
        o_legal = 1'b1;
        case (i_op)
            CMD_ADD:   o_word = rtype_word(i_rs, i_rt, i_rd, F_ADD);
            CMD_SUB:   o_word = rtype_word(i_rs, i_rt, i_rd, F_SUB);
            CMD_AND:   o_word = rtype_word(i_rs, i_rt, i_rd, F_AND);
            CMD_OR:    o_word = rtype_word(i_rs, i_rt, i_rd, F_OR);
            CMD_SLT:   o_word = rtype_word(i_rs, i_rt, i_rd, F_SLT);
            CMD_JMADD: o_word = rtype_word(i_rs, i_rt, i_rd, F_JMADD);
            CMD_LW:    o_word = itype_word(OP_LW,  i_rs, i_rt, i_imm);
            CMD_SW:    o_word = itype_word(OP_SW,  i_rs, i_rt, i_imm);
            CMD_BEQ:   o_word = itype_word(OP_BEQ, i_rs, i_rt, i_imm);
            CMD_BMN:   o_word = itype_word(OP_BMN, i_rs, i_rt, i_imm);
            CMD_JAL:   o_word = {OP_JAL, i_target};
            default:   o_legal = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/instr_loader.sv
//==============================================================================
// Module : instr_loader
// Streams encoded instructions into instruction memory while holding the CPU.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module instr_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [4:0]        cmd_rs,
    input  logic [4:0]        cmd_rt,
    input  logic [4:0]        cmd_rd,
    input  logic [15:0]       cmd_imm,
    input  logic [25:0]       cmd_target,
    input  logic              cmd_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err_illegal,
    output logic              err_overflow
);

    localparam logic [ADDR_W-1:0] c_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] c_LAST = {ADDR_W{1'b1}};

    ld_state_e         r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic              r_we, w_we_nxt;
    logic [ADDR_W-1:0] r_waddr, w_waddr_nxt;
    logic [31:0]       r_wdata, w_wdata_nxt;
    logic              r_done, w_done_nxt;
    logic              r_hold, w_hold_nxt;
    logic              r_loaded, w_loaded_nxt;
    logic              r_err_ill, w_err_ill_nxt;
    logic              r_err_ovf, w_err_ovf_nxt;

    logic [31:0]       w_word;
    logic              w_legal;
    logic              w_accept;

    instr_encoder u_enc (
        .i_op     (cmd_op),
        .i_rs     (cmd_rs),
        .i_rt     (cmd_rt),
        .i_rd     (cmd_rd),
        .i_imm    (cmd_imm),
        .i_target (cmd_target),
        .o_word   (w_word),
        .o_legal  (w_legal)
    );

    assign cmd_ready = (r_state == ST_LOAD);
    assign w_accept  = cmd_ready & cmd_valid;

    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_addr;
        w_we_nxt      = 1'b0;
        w_waddr_nxt   = r_waddr;
        w_wdata_nxt   = r_wdata;
        w_done_nxt    = 1'b0;
        w_hold_nxt    = r_hold;
        w_loaded_nxt  = r_loaded;
        w_err_ill_nxt = r_err_ill;
        w_err_ovf_nxt = r_err_ovf;
        case (r_state)
            ST_IDLE: begin
                w_hold_nxt = ~r_loaded;
                if (start) begin
                    w_err_ill_nxt = 1'b0;
                    w_err_ovf_nxt = 1'b0;
                    w_addr_nxt    = c_BASE;
                    w_hold_nxt    = 1'b1;
                    w_state_nxt   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_accept) begin
                    if (w_legal) begin
                        w_we_nxt    = 1'b1;
                        w_waddr_nxt = r_addr;
                        w_wdata_nxt = w_word;
                        // Counter saturates at the top word; the session ends there.
                        if (r_addr != c_LAST) begin
                            w_addr_nxt = r_addr + ADDR_W'(1);
                        end
                    end else begin
                        w_err_ill_nxt = 1'b1;
                    end
                    if (cmd_last) begin
                        w_state_nxt = ST_DONE;
                    end else if (w_legal && (r_addr == c_LAST)) begin
                        w_err_ovf_nxt = 1'b1;
                        w_state_nxt   = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_done_nxt   = 1'b1;
                w_loaded_nxt = 1'b1;
                w_hold_nxt   = 1'b0;
                w_state_nxt  = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_addr    <= c_BASE;
            r_we      <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_done    <= 1'b0;
            r_hold    <= 1'b1;
            r_loaded  <= 1'b0;
            r_err_ill <= 1'b0;
            r_err_ovf <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_we      <= w_we_nxt;
            r_waddr   <= w_waddr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_done    <= w_done_nxt;
            r_hold    <= w_hold_nxt;
            r_loaded  <= w_loaded_nxt;
            r_err_ill <= w_err_ill_nxt;
            r_err_ovf <= w_err_ovf_nxt;
        end
    end

    assign imem_we      = r_we;
    assign imem_addr    = r_waddr;
    assign imem_wdata   = r_wdata;
    assign cpu_hold     = r_hold;
    assign done         = r_done;
    assign err_illegal  = r_err_ill;
    assign err_overflow = r_err_ovf;

endmodule

`default_nettype wire

// File: tb/tb_instr_loader.sv
//==============================================================================
// Module : tb_instr_loader
// Scoreboard bench for instr_loader (default 8-bit and 2-bit address builds).
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_instr_loader;

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start8, start2;
    logic        cmd_valid;
    logic [3:0]  cmd_op;
    logic [4:0]  cmd_rs, cmd_rt, cmd_rd;
    logic [15:0] cmd_imm;
    logic [25:0] cmd_target;
    logic        cmd_last;

    logic        rdy8, we8, hold8, done8, ill8, ovf8;
    logic [7:0]  addr8;
    logic [31:0] wdata8;
    logic        rdy2, we2, hold2, done2, ill2, ovf2;
    logic [1:0]  addr2;
    logic [31:0] wdata2;

    wr_t q8[$];
    wr_t q2[$];
    int  exp8, exp2;
    int  checks   = 0;
    int  failures = 0;

    always #5 clk = ~clk;

    instr_loader u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .cmd_valid(cmd_valid), .cmd_ready(rdy8),
        .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
        .cmd_target(cmd_target), .cmd_last(cmd_last), .imem_we(we8), .imem_addr(addr8),
        .imem_wdata(wdata8), .cpu_hold(hold8), .done(done8), .err_illegal(ill8),
        .err_overflow(ovf8)
    );

    instr_loader #(.ADDR_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .cmd_valid(cmd_valid), .cmd_ready(rdy2),
        .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
        .cmd_target(cmd_target), .cmd_last(cmd_last), .imem_we(we2), .imem_addr(addr2),
        .imem_wdata(wdata2), .cpu_hold(hold2), .done(done2), .err_illegal(ill2),
        .err_overflow(ovf2)
    );

    // Independent reference encoding for the randomised-gap stream.
    function automatic logic [32:0] ref_enc(input logic [3:0] op, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [4:0] rd,
                                            input logic [15:0] imm, input logic [25:0] tgt);
        case (op)
            4'd0:    return {1'b1, 6'd0, rs, rt, rd, 5'd0, 6'd32};
            4'd1:    return {1'b1, 6'd0, rs, rt, rd, 5'd0, 6'd34};
            4'd2:    return {1'b1, 6'd0, rs, rt, rd, 5'd0, 6'd36};
            4'd3:    return {1'b1, 6'd0, rs, rt, rd, 5'd0, 6'd37};
            4'd4:    return {1'b1, 6'd0, rs, rt, rd, 5'd0, 6'd42};
            4'd5:    return {1'b1, 6'd0, rs, rt, rd, 5'd0, 6'd31};
            4'd6:    return {1'b1, 6'd35, rs, rt, imm};
            4'd7:    return {1'b1, 6'd43, rs, rt, imm};
            4'd8:    return {1'b1, 6'd4,  rs, rt, imm};
            4'd9:    return {1'b1, 6'd21, rs, rt, imm};
            4'd10:   return {1'b1, 6'd3,  tgt};
            default: return {1'b0, 32'd0};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && we8 === 1'b1) begin
            checks++;
            if (q8.size() == 0) begin
                failures++;
                $display("FAIL wr8_unexpected actual=%0h:%08h required=none", addr8, wdata8);
            end else begin
                wr_t e;
                e = q8.pop_front();
                if (addr8 !== e.a || wdata8 !== e.d) begin
                    failures++;
                    $display("FAIL wr8 actual=%0h:%08h required=%0h:%08h", addr8, wdata8, e.a, e.d);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && we2 === 1'b1) begin
            checks++;
            if (q2.size() == 0) begin
                failures++;
                $display("FAIL wr2_unexpected actual=%0h:%08h required=none", addr2, wdata2);
            end else begin
                wr_t e;
                e = q2.pop_front();
                if (addr2 !== e.a[1:0] || wdata2 !== e.d) begin
                    failures++;
                    $display("FAIL wr2 actual=%0h:%08h required=%0h:%08h", addr2, wdata2, e.a, e.d);
                end
            end
        end
    end

    task automatic do_start(input bit sel2);
        if (sel2) begin start2 = 1'b1; exp2 = 0; end
        else      begin start8 = 1'b1; exp8 = 0; end
        @(negedge clk);
        start8 = 1'b0;
        start2 = 1'b0;
        chk(sel2 ? "ready_after_start2" : "ready_after_start8", {31'd0, sel2 ? rdy2 : rdy8}, 32'd1);
    endtask

    // Called just after a negedge; returns just after a negedge with cmd_valid still high.
    task automatic send(input bit sel2, input logic [3:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                        input logic [25:0] tgt, input logic last, input logic exp_wr,
                        input logic [31:0] exp_data, input int budget, output bit acc);
        wr_t e;
        cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd;
        cmd_imm = imm; cmd_target = tgt; cmd_last = last; cmd_valid = 1'b1;
        acc = 1'b0;
        for (int c = 0; c < budget && !acc; c++) begin
            if ((sel2 ? rdy2 : rdy8) === 1'b1) begin
                acc = 1'b1;
                if (exp_wr) begin
                    e.d = exp_data;
                    if (sel2) begin e.a = 8'(exp2); q2.push_back(e); exp2++; end
                    else      begin e.a = 8'(exp8); q8.push_back(e); exp8++; end
                end
                @(posedge clk);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        logic [32:0] r;
        logic [3:0]  op;
        int          seen;

        rst_n = 1'b0; start8 = 1'b0; start2 = 1'b0; cmd_valid = 1'b0;
        cmd_op = '0; cmd_rs = '0; cmd_rt = '0; cmd_rd = '0;
        cmd_imm = '0; cmd_target = '0; cmd_last = 1'b0;
        exp8 = 0; exp2 = 0;
        repeat (3) @(negedge clk);
        chk("rst_hold",  {31'd0, hold8}, 32'd1);
        chk("rst_ready", {31'd0, rdy8},  32'd0);
        chk("rst_we",    {31'd0, we8},   32'd0);
        chk("rst_done",  {31'd0, done8}, 32'd0);
        chk("rst_errs",  {30'd0, ill8, ovf8}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single ADD with last: write, then done pulse and hold release.
        do_start(1'b0);
        send(1'b0, 4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b1, 1'b1, 32'h00221820, 4, acc);
        cmd_valid = 1'b0;
        chk("t1_acc", {31'd0, acc}, 32'd1);
        chk("t1_ready_low", {31'd0, rdy8}, 32'd0);
        chk("t1_done_early", {31'd0, done8}, 32'd0);
        chk("t1_hold_loading", {31'd0, hold8}, 32'd1);
        @(negedge clk);
        chk("t1_done", {31'd0, done8}, 32'd1);
        chk("t1_hold_released", {31'd0, hold8}, 32'd0);
        @(negedge clk);
        chk("t1_done_one_cycle", {31'd0, done8}, 32'd0);

        // Back-to-back I/J/R mix, one accept per cycle.
        do_start(1'b0);
        send(1'b0, 4'd6,  5'd29, 5'd8, 5'd0, 16'd4,    26'd0,    1'b0, 1'b1, 32'h8FA80004, 1, acc);
        chk("t2_lw_acc", {31'd0, acc}, 32'd1);
        send(1'b0, 4'd9,  5'd4,  5'd5, 5'd0, 16'hFFFF, 26'd0,    1'b0, 1'b1, 32'h5485FFFF, 1, acc);
        chk("t2_bmn_acc", {31'd0, acc}, 32'd1);
        send(1'b0, 4'd10, 5'd0,  5'd0, 5'd0, 16'd0,    26'h10,   1'b0, 1'b1, 32'h0C000010, 1, acc);
        chk("t2_jal_acc", {31'd0, acc}, 32'd1);
        send(1'b0, 4'd5,  5'd6,  5'd7, 5'd0, 16'd0,    26'd0,    1'b1, 1'b1, 32'h00C7001F, 1, acc);
        chk("t2_jmadd_acc", {31'd0, acc}, 32'd1);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t2_no_illegal", {31'd0, ill8}, 32'd0);

        // Illegal op between two ADDs is consumed without a write.
        do_start(1'b0);
        send(1'b0, 4'd0,  5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0, 1'b1, 32'h00221820, 4, acc);
        send(1'b0, 4'd12, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0, 1'b0, 32'h0,        4, acc);
        chk("t3_illegal_acc", {31'd0, acc}, 32'd1);
        send(1'b0, 4'd0,  5'd4, 5'd5, 5'd6, 16'd0, 26'd0, 1'b1, 1'b1, 32'h00853020, 4, acc);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t3_err_illegal", {31'd0, ill8}, 32'd1);
        chk("t3_no_overflow", {31'd0, ovf8}, 32'd0);

        // Four-word memory fills without last.
        do_start(1'b1);
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0, 1'b1, 32'h00221820, 4, acc);
            chk("t4_acc", {31'd0, acc}, 32'd1);
        end
        chk("t4_ready_low", {31'd0, rdy2}, 32'd0);
        @(negedge clk);
        chk("t4_done", {31'd0, done2}, 32'd1);
        chk("t4_overflow", {31'd0, ovf2}, 32'd1);
        chk("t4_hold_released", {31'd0, hold2}, 32'd0);
        send(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0, 1'b1, 32'h00221820, 4, acc);
        chk("t4_fifth_rejected", {31'd0, acc}, 32'd0);
        cmd_valid = 1'b0;
        q2.delete();

        // Reset mid-session drops the pending write.
        do_start(1'b0);
        chk("t5_err_cleared", {31'd0, ill8}, 32'd0);
        send(1'b0, 4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0, 1'b1, 32'h00221820, 4, acc);
        cmd_op = 4'd1; cmd_rs = 5'd1; cmd_rt = 5'd2; cmd_rd = 5'd3; cmd_last = 1'b0;
        cmd_valid = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("t5_we_dropped", {31'd0, we8},   32'd0);
        chk("t5_ready",      {31'd0, rdy8},  32'd0);
        chk("t5_hold",       {31'd0, hold8}, 32'd1);
        chk("t5_addr",       {24'd0, addr8}, 32'd0);
        cmd_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_hold_idle", {31'd0, hold8}, 32'd1);
        do_start(1'b0);
        send(1'b0, 4'd0, 5'd7, 5'd8, 5'd9, 16'd0, 26'd0, 1'b1, 1'b1, 32'h00E84820, 4, acc);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Randomly gapped stream against the reference encoder.
        do_start(1'b0);
        for (int i = 0; i < 14; i++) begin
            repeat ($urandom_range(0, 2)) begin
                cmd_valid = 1'b0;
                @(negedge clk);
            end
            op = (i == 5) ? 4'd13 : 4'(i % 11);
            cmd_rs = 5'($urandom); cmd_rt = 5'($urandom); cmd_rd = 5'($urandom);
            cmd_imm = 16'($urandom); cmd_target = 26'($urandom);
            r = ref_enc(op, cmd_rs, cmd_rt, cmd_rd, cmd_imm, cmd_target);
            send(1'b0, op, cmd_rs, cmd_rt, cmd_rd, cmd_imm, cmd_target, (i == 13),
                 r[32], r[31:0], 4, acc);
            chk("t6_acc", {31'd0, acc}, 32'd1);
        end
        cmd_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 5 && seen == 0; c++) begin
            if (done8 === 1'b1) seen = 1;
            @(negedge clk);
        end
        chk("t6_done_seen", 32'(seen), 32'd1);
        chk("t6_err_illegal", {31'd0, ill8}, 32'd1);

        repeat (3) @(negedge clk);
        chk("sb8_drained", 32'(q8.size()), 32'd0);
        chk("sb2_drained", 32'(q2.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
